// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - i_regbus: two-port register read bus between ID stage (master) and regfile (slave)
interface i_regbus #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          r1_en;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_data;
  logic          r2_en;
  logic [AW-1:0] r2_addr;
  logic [DW-1:0] r2_data;

  modport master (
    output r1_en, r1_addr, r2_en, r2_addr,
    input  r1_data, r2_data
  );

  modport slave (
    input  r1_en, r1_addr, r2_en, r2_addr,
    output r1_data, r2_data
  );
endinterface

// File: rtl/regfile.sv
// rtl/regfile.sv - MIPS GPR file: 2 comb read ports with WB bypass, $0 hardwired zero
// Optional post-reset clear sweep (busy NREGS-1 cycles) under REGFILE_INIT_SWEEP_EN.
module regfile #(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  i_regbus.slave                             read,
  input  logic [$clog2(NREGS)+DATA_W:0]      wb_wreg_i,
  output logic                               rf_busy_o
);
  localparam int AW = $clog2(NREGS);

  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  assign {wb_en, wb_addr, wb_data} = wb_wreg_i;

  logic [DATA_W-1:0] regs [NREGS];
  logic              ready;
  logic              wb_hit;

  assign wb_hit = wb_en && (wb_addr != '0);

`ifdef REGFILE_INIT_SWEEP_EN
  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t        state, state_nxt;
  logic [AW-1:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      idx   <= AW'(1);
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && idx == AW'(NREGS - 1)) state_nxt = S_READY;
  end

  always_comb begin
    ready     = (state == S_READY);
    rf_busy_o = (state == S_CLEAR);
  end

  // No per-entry reset so the array can map onto RAM; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready)      regs[idx]     <= '0;
      else if (wb_hit) regs[wb_addr] <= wb_data;
    end
  end
`else
  assign ready     = 1'b1;
  assign rf_busy_o = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end
`endif

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic              blocked,
    input logic              en,
    input logic [AW-1:0]     addr,
    input logic [DATA_W-1:0] stored
  );
    if (blocked || !en || addr == '0) return '0;
    if (wb_en && wb_addr == addr)     return wb_data;
    return stored;
  endfunction

  always_comb begin
    read.r1_data = rd_sel(rst || !ready, read.r1_en, read.r1_addr, regs[read.r1_addr]);
    read.r2_data = rd_sel(rst || !ready, read.r2_en, read.r2_addr, regs[read.r2_addr]);
  end
endmodule
